// File: rtl/fft_bin_serializer.sv
// Captures a 32-bin complex FFT frame on a strobe and streams the bins out
// one per accepted valid/ready beat, with index, re/im and L1 magnitude.
module fft_bin_serializer #(
    parameter int N    = 32,
    parameter int W    = 16,
    parameter int IDXW = 5
) (
    input  logic               clk_100,
    input  logic               reset,
    input  logic [N*2*W-1:0]   frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDXW-1:0]    bin_idx,
    output logic [W-1:0]       bin_re,
    output logic [W-1:0]       bin_im,
    output logic [W:0]         bin_mag,
    output logic               out_last,
    output logic [7:0]         drop_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_next;
    logic [2*W-1:0]  buffer [N];
    logic [IDXW-1:0] idx, idx_next;
    logic            at_end, accept, capture, drop;
    logic [W-1:0]    re, im;
    logic [W:0]      re_ext, im_ext, abs_re, abs_im;

    always_comb begin
        out_valid   = (state == SEND);
        at_end      = (idx == IDXW'(N - 1));
        accept      = out_valid & out_ready;
        out_last    = out_valid & at_end;
        frame_ready = (state == IDLE) | (accept & at_end);
        capture     = frame_valid & frame_ready;
        drop        = frame_valid & ~frame_ready;
        state_next  = state;
        idx_next    = idx;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (!at_end) begin
                        idx_next = idx + IDXW'(1);
                    end else if (capture) begin
                        idx_next = '0;
                    end else begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Magnitude is formed in W+1 bits so abs(-2^(W-1)) stays exact.
    always_comb begin
        re      = buffer[idx][2*W-1:W];
        im      = buffer[idx][W-1:0];
        re_ext  = {re[W-1], re};
        im_ext  = {im[W-1], im};
        abs_re  = re[W-1] ? ((W+1)'(0) - re_ext) : re_ext;
        abs_im  = im[W-1] ? ((W+1)'(0) - im_ext) : im_ext;
        bin_idx = out_valid ? idx : '0;
        bin_re  = out_valid ? re : '0;
        bin_im  = out_valid ? im : '0;
        bin_mag = out_valid ? (abs_re + abs_im) : '0;
    end

    always_ff @(posedge clk_100) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Buffer needs no reset: it is only observable while out_valid is high.
    always_ff @(posedge clk_100) begin
        if (reset && capture) begin
            for (int unsigned k = 0; k < N; k++) begin
                buffer[k] <= frame_in[k*2*W +: 2*W];
            end
        end
    end

endmodule
